// File: rtl/reset_sequencer.sv
// Staged reset sequencer: synchronizes reset release, holds all stages for MIN_PULSE
// cycles, then releases stages one by one every STAGE_DLY cycles; soft requests restart from HOLD.
module reset_sequencer #(
    parameter int NUM_STAGES  = 3,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_PULSE   = 8,
    parameter int STAGE_DLY   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  soft_req,
    output logic [NUM_STAGES-1:0] stage_rst_n,
    output logic                  soft_ack,
    output logic                  seq_busy,
    output logic                  seq_done
);

    localparam int CNT_MAX = (MIN_PULSE > STAGE_DLY) ? MIN_PULSE : STAGE_DLY;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(MIN_PULSE - 1);
    localparam logic [CW-1:0] REL_LAST  = CW'(STAGE_DLY - 1);

    typedef enum logic [1:0] {
        ASSERT,
        HOLD,
        RELEASE,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0]  sync_q, sync_d;
    logic [NUM_STAGES-1:0]   stage_d, stage_shift;
    logic                    ack_d, busy_d, done_d;

    assign stage_shift = (stage_rst_n << 1) | NUM_STAGES'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_rst_n;
        ack_d   = 1'b0;
        busy_d  = seq_busy;
        done_d  = seq_done;
        sync_d  = {sync_q[SYNC_STAGES-2:0], 1'b1};

        case (state_q)
            ASSERT: begin
                // Leave on the edge that raises the synchronizer output, not one edge later.
                if (sync_d[SYNC_STAGES-1] && !sync_q[SYNC_STAGES-1]) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            HOLD, RELEASE: begin
                if (cnt_q == ((state_q == HOLD) ? HOLD_LAST : REL_LAST)) begin
                    stage_d = stage_shift;
                    cnt_d   = '0;
                    if (&stage_shift) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (soft_req) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    stage_d = '0;
                    ack_d   = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            default: state_d = ASSERT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ASSERT;
            cnt_q       <= '0;
            sync_q      <= '0;
            stage_rst_n <= '0;
            soft_ack    <= 1'b0;
            seq_busy    <= 1'b1;
            seq_done    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sync_q      <= sync_d;
            stage_rst_n <= stage_d;
            soft_ack    <= ack_d;
            seq_busy    <= busy_d;
            seq_done    <= done_d;
        end
    end

endmodule
